// File: rtl/apb_pkg.sv
// apb_pkg: shared APB types for the simulation-side requesters, the arbiter
// and the APB target model.
//   apb_req_t       - one complete APB request (address, data, direction, strobes, protection)
//   apb_resp_t      - completer response (read data, error flag)
//   apb_arb_state_e - bus-phase state of apb_arbiter
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

   typedef struct packed {
      logic [APB_ADDR_WIDTH-1:0] addr;
      logic [APB_DATA_WIDTH-1:0] wdata;
      logic                      write;
      logic [APB_STRB_WIDTH-1:0] strb;
      logic [2:0]                prot;
   } apb_req_t;

   typedef struct packed {
      logic [APB_DATA_WIDTH-1:0] rdata;
      logic                      slverr;
   } apb_resp_t;

   // Upper bound on the number of requesters sharing one completer.
   localparam int APB_ARB_MAX_REQ = 16;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin picker with an internal rotating pointer.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i          request vector
//   grant_en_i     a grant may be issued this cycle
//   grant_o        one-hot grant (all zero when nothing is granted)
//   grant_idx_o    index of the granted requester (zero when nothing is granted)
// The pointer holds the last granted index; the search starts one above it
// and wraps, so after reset requester 0 has top priority.
module apb_rr_arbiter
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               grant_en_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grant_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   always_comb begin
      int unsigned      cand;
      logic             found;
      logic [IDX_W-1:0] pick;
      cand        = 0;
      found       = 1'b0;
      pick        = '0;
      grant_o     = '0;
      grant_idx_o = '0;
      ptr_d       = ptr_q;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && req_i[IDX_W'(cand)]) begin
            found = 1'b1;
            pick  = IDX_W'(cand);
         end
      end
      if (grant_en_i && found) begin
         grant_o[pick] = 1'b1;
         grant_idx_o   = pick;
         ptr_d         = pick;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= IDX_W'(NUM_REQ - 1);
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one APB completer between NUM_REQ requesters.
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/_ready_o  per-requester request handshake; ready is combinational in IDLE
//   req_i                 per-requester apb_req_t
//   resp_valid_o, resp_o  one-hot single-cycle response strobe, broadcast response
//   p*_o, psel_o, penable_o, prdata_i, pready_i, pslverr_i   APB completer side
//   busy_o                high in SETUP or ACCESS
//   dbg_state_o           current bus-phase state
// Handshake: a request transfers in a cycle where req_valid_i[g] and
// req_ready_o[g] are both high; the requester holds valid and data stable
// until then (or withdraws). Responses cannot be back-pressured.
module apb_arbiter
   import apb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  apb_req_t [NUM_REQ-1:0]        req_i,
   output logic [NUM_REQ-1:0]            resp_valid_o,
   output apb_resp_t                     resp_o,
   output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
   output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
   output logic                          pwrite_o,
   output logic [APB_STRB_WIDTH-1:0]     pstrb_o,
   output logic [2:0]                    pprot_o,
   output logic                          psel_o,
   output logic                          penable_o,
   input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
   input  logic                          pready_i,
   input  logic                          pslverr_i,
   output logic                          busy_o,
   output apb_arb_state_e                dbg_state_o
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // A zero TIMEOUT still needs a legal (unused) counter width.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_arb_state_e   state_q, state_d;
   apb_req_t         req_q, req_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   apb_resp_t        resp_q, resp_d;
   logic             resp_valid_q, resp_valid_d;

   logic               grant_en;
   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               accept;
   logic               timed_out;

   // Gating with rst_ni keeps req_ready_o low while reset is asserted,
   // even though the FSM already sits in IDLE.
   assign grant_en  = (state_q == ARB_IDLE) && rst_ni;
   assign accept    = |arb_grant;
   assign timed_out = (TIMEOUT != 0) && (state_q == ARB_ACCESS) && !pready_i
                      && (cnt_q == TO_LAST);

   apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req_valid_i),
      .grant_en_i  (grant_en),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
   );

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ARB_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE:   if (accept) state_d = ARB_SETUP;
         ARB_SETUP:  state_d = ARB_ACCESS;
         ARB_ACCESS: if (pready_i || timed_out) state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   // Request latch, wait counter and response capture
   always_comb begin
      req_d        = req_q;
      gidx_d       = gidx_q;
      cnt_d        = cnt_q;
      resp_d       = resp_q;
      resp_valid_d = 1'b0;
      if (accept) begin
         req_d  = req_i[arb_idx];
         gidx_d = arb_idx;
      end
      // Cleared while in SETUP so the first ACCESS cycle sees zero; saturates.
      if (state_q == ARB_SETUP) begin
         cnt_d = '0;
      end else if (state_q == ARB_ACCESS && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (state_q == ARB_ACCESS && pready_i) begin
         resp_d.rdata  = prdata_i;
         resp_d.slverr = pslverr_i;
         resp_valid_d  = 1'b1;
      end else if (timed_out) begin
         resp_d.rdata  = '0;
         resp_d.slverr = 1'b1;
         resp_valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_q        <= '0;
         gidx_q       <= '0;
         cnt_q        <= '0;
         resp_q       <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         req_q        <= req_d;
         gidx_q       <= gidx_d;
         cnt_q        <= cnt_d;
         resp_q       <= resp_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   // FSM outputs and bus fields (zero whenever psel_o is low)
   always_comb begin
      psel_o       = (state_q != ARB_IDLE);
      penable_o    = (state_q == ARB_ACCESS);
      busy_o       = psel_o;
      dbg_state_o  = state_q;
      req_ready_o  = arb_grant;
      resp_o       = resp_q;
      paddr_o      = '0;
      pwdata_o     = '0;
      pwrite_o     = 1'b0;
      pstrb_o      = '0;
      pprot_o      = '0;
      if (psel_o) begin
         paddr_o  = req_q.addr;
         pwdata_o = req_q.wdata;
         pwrite_o = req_q.write;
         pstrb_o  = req_q.strb;
         pprot_o  = req_q.prot;
      end
      resp_valid_o = '0;
      if (resp_valid_q) resp_valid_o[gidx_q] = 1'b1;
   end

endmodule

// File: tb/tb_apb_arbiter.sv
module tb_apb_arbiter;
   import apb_pkg::*;

   localparam int NREQ = 4;
   localparam int TOUT = 8;

   typedef struct packed {
      logic [1:0]  idx;
      logic [31:0] rdata;
      logic        slverr;
      logic [31:0] cyc;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [31:0] prdata;
      logic        slverr;
      int          waits;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
      int          exp_lat;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   apb_req_t [NREQ-1:0] req_tb = '0;
   logic [NREQ-1:0]     resp_valid;
   apb_resp_t           resp;
   logic [31:0]         paddr, pwdata, prdata = '0;
   logic                pwrite, psel, penable, busy;
   logic [3:0]          pstrb;
   logic [2:0]          pprot;
   logic                pready = 1'b0, pslverr = 1'b0;
   apb_arb_state_e      dbg_state;

   apb_arbiter #(.NUM_REQ(NREQ), .TIMEOUT(TOUT)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_i        (req_tb),
      .resp_valid_o (resp_valid),
      .resp_o       (resp),
      .paddr_o      (paddr),
      .pwdata_o     (pwdata),
      .pwrite_o     (pwrite),
      .pstrb_o      (pstrb),
      .pprot_o      (pprot),
      .psel_o       (psel),
      .penable_o    (penable),
      .prdata_i     (prdata),
      .pready_i     (pready),
      .pslverr_i    (pslverr),
      .busy_o       (busy),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [EXP_W-1:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int idx, input logic [31:0] rdata, input logic slverr, input int at_cyc);
      exp_t e;
      e.idx    = 2'(idx);
      e.rdata  = rdata;
      e.slverr = slverr;
      e.cyc    = 32'(at_cyc);
      exp_q.push_back(e);
   endtask

   // Monitor: responses against the expected queue, plus bus invariants.
   always @(negedge clk) begin : mon
      exp_t       e;
      logic [3:0] oh;
      if (busy) chk("ready_while_busy", req_ready, 0);
      if (!psel) chk("fields_zero_idle", {paddr, pwdata, pwrite, pstrb, pprot}, 0);
      if (resp_valid != '0) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", resp_valid, 0);
         end else begin
            e  = exp_t'(exp_q.pop_front());
            oh = 4'b0001 << e.idx;
            chk("resp_valid", resp_valid, oh);
            chk("resp_rdata", resp.rdata, e.rdata);
            chk("resp_slverr", resp.slverr, e.slverr);
            chk("resp_cycle", cyc, e.cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_vec(input vec_t v);
      logic [3:0]  oh;
      logic [71:0] flds;
      oh   = 4'b0001 << v.idx;
      flds = {v.addr, v.wdata, v.write, v.strb, v.prot};
      @(posedge clk); #1;
      req_tb[v.idx]    = '{addr: v.addr, wdata: v.wdata, write: v.write, strb: v.strb, prot: v.prot};
      req_valid[v.idx] = 1'b1;
      @(negedge clk);
      chk("vec_ready", req_ready, oh);
      push_exp(v.idx, v.exp_rdata, v.exp_slverr, cyc + v.exp_lat);
      // pready/pslverr high during SETUP must be ignored
      @(posedge clk); #1;
      req_valid = '0; pready = 1'b1; prdata = 32'hBAD0_BAD0; pslverr = 1'b1;
      @(negedge clk);
      chk("setup_ctrl", {psel, penable, busy}, 3'b101);
      chk("setup_fields", {paddr, pwdata, pwrite, pstrb, pprot}, flds);
      for (int w = 0; w <= v.waits; w++) begin
         @(posedge clk); #1;
         pready  = (w == v.waits);
         prdata  = v.prdata;
         pslverr = (w == v.waits) ? v.slverr : 1'b1;
         @(negedge clk);
         chk("access_ctrl", {psel, penable, dbg_state == ARB_ACCESS}, 3'b111);
         chk("access_fields", {paddr, pwdata, pwrite, pstrb, pprot}, flds);
      end
      @(posedge clk); #1;
      pready = 1'b0; pslverr = 1'b0;
      @(negedge clk);
      chk("after_idle", {psel, busy}, 2'b00);
   endtask

   // Completes a transfer accepted at the current negedge: zero-wait read.
   task automatic finish_simple(input int idx, input logic [31:0] rdata);
      push_exp(idx, rdata, 1'b0, cyc + 3);
      @(posedge clk); #1;
      req_valid = '0; pready = 1'b1; prdata = rdata; pslverr = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      pready = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_req(input int idx, input logic [31:0] addr);
      req_tb[idx] = '{addr: addr, wdata: 32'h0, write: 1'b0, strb: 4'hF, prot: 3'd0};
   endtask

   // ---------------- test ----------------
   vec_t vecs[8];
   int   order[6] = '{0, 1, 2, 3, 0, 1};

   initial begin
      int   last;
      int   acc;
      int   t0;
      logic got;

      // stimulus table
      vecs[0] = '{0, 32'h0000_0100, 32'h0,          1'b0, 4'h0, 3'd0, 32'hDEAD_BEEF, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 3};
      vecs[1] = '{1, 32'h0000_0200, 32'h1234_5678, 1'b1, 4'hF, 3'd0, 32'h0000_0000, 1'b1, 5, 32'h0000_0000, 1'b1, 8};
      vecs[2] = '{3, 32'hFFFF_FFFC, 32'h0,          1'b0, 4'h0, 3'd7, 32'h55AA_55AA, 1'b0, 6, 32'h55AA_55AA, 1'b0, 9};
      vecs[3] = '{2, 32'h0000_0040, 32'hCAFE_F00D, 1'b1, 4'h5, 3'd2, 32'h0BAD_CAFE, 1'b0, 1, 32'h0BAD_CAFE, 1'b0, 4};
      for (int i = 4; i < 8; i++) begin
         vecs[i].idx        = int'($urandom_range(0, 3));
         vecs[i].addr       = $urandom() & 32'hFFFF_FFFC;
         vecs[i].wdata      = $urandom();
         vecs[i].write      = 1'($urandom_range(0, 1));
         vecs[i].strb       = 4'($urandom_range(0, 15));
         vecs[i].prot       = 3'($urandom_range(0, 7));
         vecs[i].prdata     = $urandom();
         vecs[i].slverr     = 1'($urandom_range(0, 1));
         vecs[i].waits      = int'($urandom_range(0, 6));
         vecs[i].exp_rdata  = vecs[i].prdata;
         vecs[i].exp_slverr = vecs[i].slverr;
         vecs[i].exp_lat    = 3 + vecs[i].waits;
      end

      // reset values, with a request pending during reset
      req_valid = 4'b0001;
      @(negedge clk);
      chk("rst_ctrl", {psel, penable, busy}, 3'b000);
      chk("rst_ready", req_ready, 0);
      chk("rst_resp", {resp_valid, resp}, 0);
      chk("rst_fields", {paddr, pwdata, pwrite, pstrb, pprot}, 0);
      chk("rst_state", dbg_state, ARB_IDLE);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // fairness: all requesters hold valid continuously
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000 + 32'(i * 4));
      req_valid = '1; pready = 1'b1; pslverr = 1'b0;
      last = 0;
      for (int k = 0; k < 6; k++) begin
         got = 1'b0;
         for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1'b1;
         end
         chk("fair_ready_seen", got, 1);
         if (got) begin
            chk("fair_order", req_ready, 4'b0001 << order[k]);
            if (k > 0) chk("fair_spacing", cyc - last, 3);
            last = cyc;
            push_exp(order[k], 32'hF000_0000 + 32'(k), 1'b0, cyc + 3);
         end
         @(posedge clk); #1;
         prdata = 32'hF000_0000 + 32'(k);
         if (k == 5) req_valid = '0;
      end
      repeat (4) @(posedge clk);
      #1 pready = 1'b0;

      // table-driven single transfers
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // timeout, with a second requester waiting for the bus
      @(posedge clk); #1;
      set_req(1, 32'h0000_0300);
      req_valid[1] = 1'b1;
      @(negedge clk);
      chk("tout_ready", req_ready, 4'b0010);
      t0 = cyc;
      push_exp(1, 32'h0, 1'b1, t0 + TOUT + 2);
      @(posedge clk); #1;
      req_valid = '0; pready = 1'b0; prdata = 32'h1111_1111; pslverr = 1'b0;
      @(posedge clk); #1;
      set_req(2, 32'h0000_0400);
      req_valid[2] = 1'b1;
      acc = 0;
      got = 1'b0;
      for (int n = 0; n < 30 && !got; n++) begin
         @(negedge clk);
         if (psel && penable) acc++;
         if (!psel) got = 1'b1;
      end
      chk("tout_ended", got, 1);
      chk("tout_access_cycles", acc, TOUT);
      chk("tout_next_accept", req_ready, 4'b0100);
      finish_simple(2, 32'h2222_0000);

      // valid withdrawn while the bus is busy
      @(posedge clk); #1;
      set_req(0, 32'h0000_0500);
      req_valid[0] = 1'b1;
      @(negedge clk);
      chk("wd_ready0", req_ready, 4'b0001);
      push_exp(0, 32'h3333_0000, 1'b0, cyc + 7);
      @(posedge clk); #1;
      req_valid = '0; req_valid[2] = 1'b1; pready = 1'b0;
      @(negedge clk);
      chk("wd_no_grant_setup", req_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("wd_no_grant_access", req_ready, 0);
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk); #1;
      pready = 1'b1; prdata = 32'h3333_0000;
      @(posedge clk); #1;
      pready = 1'b0;
      set_req(1, 32'h0000_0600);
      set_req(3, 32'h0000_0700);
      req_valid = 4'b1010;
      @(negedge clk);
      chk("wd_pointer", req_ready, 4'b0010);
      finish_simple(1, 32'h4444_0000);

      // reset in the middle of ACCESS: grant 1 first so the pointer is 1
      @(posedge clk); #1;
      set_req(1, 32'h0000_0800);
      req_valid[1] = 1'b1;
      @(negedge clk);
      chk("rstmid_ready", req_ready, 4'b0010);
      @(posedge clk); #1;
      req_valid = '0; pready = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_async", {psel, penable, busy}, 3'b000);
      chk("rstmid_fields", {paddr, pwdata, pwrite, pstrb, pprot}, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      set_req(0, 32'h0000_0900);
      set_req(2, 32'h0000_0A00);
      set_req(3, 32'h0000_0B00);
      req_valid = 4'b1101;
      @(negedge clk);
      chk("rstmid_first_grant", req_ready, 4'b0001);
      finish_simple(0, 32'h5555_0000);

      // drain and report
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got no end of test expected end before time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
